adsr_envelope: RTL and testbench
================================

Name: adsr_envelope

Overview:
- Per-voice ADSR envelope stage between the 3-channel waveform mixer and the master volume multiplier.
- Consumes the mixed 8-bit waveform and the gate, runs a 5-state envelope FSM on a prescaled tick, and scales the waveform by the envelope level.
- Rate and level controls come from the UART register bank.

Parameters:
- PRESCALE_W, 10: prescaler width; one envelope tick every 2^PRESCALE_W clk cycles. At 50 MHz that is 20.48 us per tick.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- gate  in  1  note gate, asynchronous to clk (pin OR register bit)
- attack_rate  in  8  attack step control
- decay_rate  in  8  decay step control
- sustain_level  in  8  sustain level
- release_rate  in  8  release step control
- wave_in  in  8  unsigned mixed waveform
- wave_out  out  8  enveloped waveform, registered
- env_level  out  8  current envelope level, acc[15:8]
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- active  out  1  high when env_state != IDLE

Behaviour:
- Interface: one clock, clk. rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge): state IDLE, acc=0, prescaler=0, sync flops=0, wave_out=0. Hence env_level=0, env_state=0, active=0.
- Gate path:
  - gate passes through a 2-flop synchronizer to give gate_s; gate_d is gate_s delayed one cycle.
  - rise = gate_s & ~gate_d.
  - fall = ~gate_s while state is ATTACK, DECAY or SUSTAIN.
  - gate sampled high at edge N gives env_state=ATTACK after edge N+2.
- Tick: prescaler is a free-running PRESCALE_W-bit counter; tick=1 in the cycle the counter equals all-ones.
- Step for the current phase: step = rate + 1, a 9-bit value in 1..256. Rate 0 is slowest (65535 ticks full scale); rate 255 gives 256 ticks.
- Accumulator acc is 16 bits; all compares are done at 17 bits with no wrap.
- Event priority each cycle, highest first:
  1. reset
  2. rise: state goes to ATTACK, acc unchanged (legato)
  3. fall: state goes to RELEASE, acc unchanged
  4. tick: level update below
- A tick coinciding with rise or fall is dropped.
- Tick update per state:
  - IDLE: acc held at 0.
  - ATTACK: if acc+step >= 0xFFFF, acc=0xFFFF and state goes to DECAY; else acc += step.
  - DECAY: target = {sustain_level, 8'h00}. If acc <= target+step, acc=target and state goes to SUSTAIN; else acc -= step. If sustain_level is raised above acc, the next tick snaps acc up to target.
  - SUSTAIN: acc = {sustain_level, 8'h00}, so it tracks register changes.
  - RELEASE: if acc <= step, acc=0 and state goes to IDLE; else acc -= step.
- Gate held high in IDLE with no edge: stays IDLE, because only rise starts a note.
- Output scaling: wave_out = (wave_in * env_level)[15:8], registered with 1 cycle latency from wave_in and env_level. env_level=0xFF gives wave_in minus at most 1.
- Rate and level inputs are sampled on the tick cycle only; no latching.

Optional Feature:
- Macro: ADSR_HARD_RETRIGGER_EN.
- Defined: rise also clears acc to 0 in the same cycle, so every note starts from silence.
- Undefined: rise keeps the current acc (legato retrigger) as specified above.
- Every other behaviour is identical in both builds.

Test Plan (PRESCALE_W=2, tick every 4 cycles):
- Reset: rst_n low for 2 edges mid-ATTACK with acc≈0x4000 -> next cycle env_level=0, env_state=0, active=0, wave_out=0.
- Full envelope: attack=255, decay=255, sustain=0x80, release=255, wave_in=0xFF, gate high.
  - ATTACK begins 3 edges after gate.
  - env_level reaches 0xFF after 256 ticks, then DECAY.
  - SUSTAIN at env_level=0x80 after ≤128 ticks; wave_out=0x7F.
  - Gate low: RELEASE, then IDLE with env_level=0 after ≤128 ticks.
- Slowest rate: attack=0 -> env_level increments by 1 every 256 ticks. Check acc wraps nowhere and clamps at 0xFFFF.
- Retrigger: gate low during RELEASE at env_level=0x40, then high -> ATTACK resumes from 0x40 (macro off) or from 0x00 (macro on).
- Edge/tick collision: gate fall aligned to a tick cycle in SUSTAIN -> state RELEASE, acc unchanged that cycle; the first decrement happens on the following tick.
- Sustain change: sustain_level changed 0x80->0xC0 during SUSTAIN -> env_level=0xC0 after the next tick.
- Sustain raised during DECAY: sustain_level raised above acc -> snaps to target on the next tick, state SUSTAIN.

Source files
------------

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE) scaling the mixed waveform; build macro ADSR_HARD_RETRIGGER_EN makes note-on restart from silence.
// Latency: gate to ATTACK 3 clk edges (2-flop sync + edge detect); wave_out registered 1 cycle after wave_in/env_level.
// Backpressure: none; free-running stream stage, level moves once per prescaler tick (every 2^PRESCALE_W clk).
module adsr_envelope #(
  parameter int PRESCALE_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  input  logic [7:0] wave_in,
  output logic [7:0] wave_out,
  output logic [7:0] env_level,
  output logic [2:0] env_state,
  output logic       active
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  state_e                state_q;
  logic [15:0]           acc_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic                  gate_meta_q;
  logic                  gate_s_q;
  logic                  gate_d_q;
  logic [7:0]            wave_out_q;

  logic                  rise;
  logic                  fall;
  logic                  tick;
  logic [8:0]            step;
  logic [16:0]           acc17;
  logic [16:0]           sum17;
  logic [16:0]           tgt_plus17;
  logic [15:0]           target;
  logic [15:0]           diff;
  logic [7:0]            scaled;

  // Phase step, 17-bit compare operands and edge/tick qualifiers for the FSM.
  always_comb begin
    step = 9'd0;
    unique case (state_q)
      ST_ATTACK:  step = {1'b0, attack_rate} + 9'd1;
      ST_DECAY:   step = {1'b0, decay_rate} + 9'd1;
      ST_RELEASE: step = {1'b0, release_rate} + 9'd1;
      default:    step = 9'd0;
    endcase
    target     = {sustain_level, 8'h00};
    acc17      = {1'b0, acc_q};
    sum17      = acc17 + {8'd0, step};
    tgt_plus17 = {1'b0, target} + {8'd0, step};
    diff       = acc_q - {7'd0, step};
    presc_d    = presc_q + PRESCALE_W'(1);
    tick       = &presc_q;
    rise       = gate_s_q & ~gate_d_q;
    fall       = ~gate_s_q & ((state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                              (state_q == ST_SUSTAIN));
  end

  // Bring the asynchronous gate into clk and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_meta_q <= 1'b0;
      gate_s_q    <= 1'b0;
      gate_d_q    <= 1'b0;
    end else begin
      gate_meta_q <= gate;
      gate_s_q    <= gate_meta_q;
      gate_d_q    <= gate_s_q;
    end
  end

  // Free-running prescaler; its all-ones cycle is the envelope tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Envelope FSM: gate edges win over the tick, and a tick in an edge cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
    end else if (rise) begin
      state_q <= ST_ATTACK;
`ifdef ADSR_HARD_RETRIGGER_EN
      acc_q   <= '0;
`else
      acc_q   <= acc_q;
`endif
    end else if (fall) begin
      state_q <= ST_RELEASE;
    end else if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          acc_q <= '0;
        end
        ST_ATTACK: begin
          if (sum17 >= 17'h0FFFF) begin
            acc_q   <= 16'hFFFF;
            state_q <= ST_DECAY;
          end else begin
            acc_q   <= sum17[15:0];
          end
        end
        ST_DECAY: begin
          // Also covers sustain raised above the current level: snap up to target.
          if (acc17 <= tgt_plus17) begin
            acc_q   <= target;
            state_q <= ST_SUSTAIN;
          end else begin
            acc_q   <= diff;
          end
        end
        ST_SUSTAIN: begin
          acc_q <= target;
        end
        ST_RELEASE: begin
          if (acc17 <= {8'd0, step}) begin
            acc_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            acc_q   <= diff;
          end
        end
        default: begin
          acc_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign scaled = 8'(({8'd0, wave_in} * {8'd0, acc_q[15:8]}) >> 8);

  // Registered output scaling: upper byte of wave_in * env_level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wave_out_q <= '0;
    end else begin
      wave_out_q <= scaled;
    end
  end

  assign wave_out  = wave_out_q;
  assign env_level = acc_q[15:8];
  assign env_state = state_q;
  assign active    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed sequences, a sustain/scaling vector table and randomized gate/rate stimulus.
// Every cycle the outputs are compared with an arithmetic envelope model kept in this bench.
// PRESCALE_W=2, so one envelope tick every 4 clk cycles.
module tb_adsr_envelope;

  localparam int PW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate = 1'b0;
  logic [7:0] attack_rate = 8'hFF;
  logic [7:0] decay_rate = 8'hFF;
  logic [7:0] sustain_level = 8'h80;
  logic [7:0] release_rate = 8'hFF;
  logic [7:0] wave_in = 8'hFF;
  logic [7:0] wave_out;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       active;

  adsr_envelope #(.PRESCALE_W(PW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .wave_in       (wave_in),
    .wave_out      (wave_out),
    .env_level     (env_level),
    .env_state     (env_state),
    .active        (active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: envelope rules in plain integer arithmetic.
  int m_acc = 0;
  int m_st  = 0;
  int m_pre = 0;
  int m_wave = 0;
  bit g1 = 0, g2 = 0, g3 = 0;

  always @(posedge clk) begin : ref_model
    int st;
    bit rise_e, fall_e, tick_e;
    if (!rst_n) begin
      m_acc = 0; m_st = 0; m_pre = 0; m_wave = 0;
      g1 = 0; g2 = 0; g3 = 0;
    end else begin
      rise_e = g2 && !g3;
      fall_e = !g2 && (m_st == 1 || m_st == 2 || m_st == 3);
      tick_e = (m_pre == (1 << PW) - 1);
      m_wave = (int'(wave_in) * (m_acc / 256)) / 256;
      if (m_st == 1)      st = int'(attack_rate) + 1;
      else if (m_st == 2) st = int'(decay_rate) + 1;
      else                st = int'(release_rate) + 1;
      if (rise_e) begin
        m_st = 1;
`ifdef ADSR_HARD_RETRIGGER_EN
        m_acc = 0;
`endif
      end else if (fall_e) begin
        m_st = 4;
      end else if (tick_e) begin
        case (m_st)
          0: m_acc = 0;
          1: if (m_acc + st >= 65535) begin m_acc = 65535; m_st = 2; end
             else m_acc = m_acc + st;
          2: if (m_acc <= int'(sustain_level) * 256 + st) begin
               m_acc = int'(sustain_level) * 256; m_st = 3;
             end else m_acc = m_acc - st;
          3: m_acc = int'(sustain_level) * 256;
          default: if (m_acc <= st) begin m_acc = 0; m_st = 0; end
                   else m_acc = m_acc - st;
        endcase
      end
      m_pre = (m_pre + 1) % (1 << PW);
      g3 = g2; g2 = g1; g1 = gate;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ref_state",  int'(env_state), m_st);
      chk("ref_level",  int'(env_level), m_acc / 256);
      chk("ref_active", int'(active),    int'(m_st != 0));
      chk("ref_wave",   int'(wave_out),  m_wave);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget, input string name, output int n);
    n = 0;
    while (int'(env_state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(env_state), s);
  endtask

  typedef struct {
    logic [7:0] sus;
    logic [7:0] wave;
    logic [7:0] exp_level;
    logic [7:0] exp_wave;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    int len;
    int exp_retrig;

    vt[0] = '{8'hC0, 8'hFF, 8'hC0, 8'hBF};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
    vt[2] = '{8'h40, 8'h80, 8'h40, 8'h20};
    vt[3] = '{8'hC0, 8'h64, 8'hC0, 8'h4B};
    vt[4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    vt[5] = '{8'hAA, 8'h55, 8'hAA, 8'h38};
    vt[6] = '{8'h01, 8'hFF, 8'h01, 8'h00};
    vt[7] = '{8'h80, 8'hFF, 8'h80, 8'h7F};

    // Power-up reset.
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("por_state",  int'(env_state), 0);
    chk("por_level",  int'(env_level), 0);
    chk("por_active", int'(active),    0);
    chk("por_wave",   int'(wave_out),  0);
    rst_n = 1'b1;
    cyc(2);

    // Reset mid-ATTACK around acc 0x4000.
    gate = 1'b1;
    wait_state(1, 6, "mid_rst_attack", n);
    n = 0;
    while (env_level < 8'h40 && n < 300) begin @(negedge clk); n++; end
    chk("mid_rst_reach40", int'(env_level >= 8'h40), 1);
    rst_n = 1'b0;
    gate  = 1'b0;
    cyc(2);
    chk("mid_rst_state",  int'(env_state), 0);
    chk("mid_rst_level",  int'(env_level), 0);
    chk("mid_rst_active", int'(active),    0);
    chk("mid_rst_wave",   int'(wave_out),  0);
    rst_n = 1'b1;
    cyc(3);

    // Full envelope: gate latency, attack length, decay to sustain, release.
    gate = 1'b1;
    cyc(1); chk("gate_lat_e1", int'(env_state), 0);
    cyc(1); chk("gate_lat_e2", int'(env_state), 0);
    cyc(1); chk("gate_lat_e3", int'(env_state), 1);
    wait_state(2, 1100, "full_decay", n);
    chk("attack_cycles", int'(n >= 1021 && n <= 1024), 1);
    chk("attack_peak", int'(env_level), 8'hFF);
    wait_state(3, 530, "full_sustain", n);
    chk("sustain_level", int'(env_level), 8'h80);
    cyc(1);
    chk("sustain_wave", int'(wave_out), 8'h7F);

    // Sustain tracking and output scaling table.
    for (int i = 0; i < 8; i++) begin
      sustain_level = vt[i].sus;
      wave_in       = vt[i].wave;
      cyc(6);
      chk("vec_state", int'(env_state), 3);
      chk("vec_level", int'(env_level), int'(vt[i].exp_level));
      chk("vec_wave",  int'(wave_out),  int'(vt[i].exp_wave));
    end

    gate = 1'b0;
    wait_state(4, 6, "full_release", n);
    wait_state(0, 530, "full_idle", n);
    chk("idle_level",  int'(env_level), 0);
    chk("idle_active", int'(active),    0);

    // Slowest attack: one level step per 256 ticks.
    attack_rate = 8'h00;
    gate = 1'b1;
    wait_state(1, 6, "slow_attack", n);
    cyc(1019); chk("slow_lvl0", int'(env_level), 0);
    cyc(6);    chk("slow_lvl1", int'(env_level), 1);
    cyc(1024); chk("slow_lvl2", int'(env_level), 2);

    // Climb to sustain 0x40 for the collision and retrigger cases.
    attack_rate = 8'hFF;
    wait_state(2, 1100, "to_decay", n);
    sustain_level = 8'h40;
    wait_state(3, 1100, "to_sustain40", n);
    chk("sustain40", int'(env_level), 8'h40);

    // Gate fall landing on a tick: state changes, level holds until the next tick.
    release_rate = 8'h00;
    n = 0;
    while (m_pre != 1 && n < 8) begin @(negedge clk); n++; end
    gate = 1'b0;
    cyc(3);
    chk("coll_state", int'(env_state), 4);
    chk("coll_level", int'(env_level), 8'h40);
    cyc(3); chk("coll_hold", int'(env_level), 8'h40);
    cyc(1); chk("coll_first_dec", int'(env_level), 8'h3F);

    // Retrigger during RELEASE.
    attack_rate = 8'h00;
    gate = 1'b1;
    wait_state(1, 6, "retrig_attack", n);
`ifdef ADSR_HARD_RETRIGGER_EN
    exp_retrig = 0;
`else
    exp_retrig = 8'h3F;
`endif
    chk("retrig_level", int'(env_level), exp_retrig);

    // Sustain raised above the level during DECAY: snap up on the next tick.
    attack_rate = 8'hFF;
    wait_state(2, 1100, "raise_decay", n);
    sustain_level = 8'h20;
    n = 0;
    while (env_level > 8'h90 && n < 600) begin @(negedge clk); n++; end
    chk("raise_below90", int'(env_level <= 8'h90 && env_state == 3'd2), 1);
    sustain_level = 8'hC0;
    decay_rate    = 8'h00;
    wait_state(3, 6, "raise_sustain", n);
    chk("raise_level", int'(env_level), 8'hC0);

    // Randomized segments against the model.
    for (int seg = 0; seg < 40; seg++) begin
      attack_rate   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(200, 255));
      decay_rate    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(200, 255));
      release_rate  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(200, 255));
      sustain_level = 8'($urandom);
      gate          = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        cyc(int'($urandom_range(1, 2)));
        rst_n = 1'b1;
      end
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(50, 600));
      for (int c = 0; c < len; c++) begin
        wave_in = 8'($urandom);
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
